// File: rtl/serializer_pkg.sv
// serializer_pkg: FSM state encoding and bit-index width helper shared by the bit serializer.
package serializer_pkg;
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;
  function automatic int idx_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/word_skid_buffer.sv
// word_skid_buffer: one-word holding register between the word input and the shifter.
//   clk, rst_n (async, active-low) | push/push_data: store a word | pop: release the word
//   full: a word is held | data: the held word
module word_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic [WIDTH-1:0] data
);
  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;
  always_comb begin
    full_d = push ? 1'b1 : pop ? 1'b0 : full_q;
    data_d = push ? push_data : data_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end
  assign full = full_q;
  assign data = data_q;
endmodule

// File: rtl/bit_serializer.sv
// bit_serializer: parallel word to valid/ready bit stream with last-bit marker.
//   clk, rst_n (async, active-low) | in_data/in_valid/in_ready: word input
//   bit_out/bit_valid/bit_ready/bit_last: serial output | busy: shifting or word buffered
//   Define BIT_SERIALIZER_SKID_EN to add a one-word buffer for gap-free back-to-back words.
module bit_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             bit_out,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic             bit_last,
  output logic             busy
);
  localparam int             IW   = idx_w(WIDTH);
  localparam logic [IW-1:0]  LAST = IW'(WIDTH - 1);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             accept, xfer, xfer_last, load_in, load_buf, buf_full;
  logic [WIDTH-1:0] buf_data;
  assign bit_valid = state_q == SHIFT;
  assign xfer      = bit_valid && bit_ready;
  assign xfer_last = xfer && idx_q == LAST;
  assign accept    = in_valid && in_ready;
`ifdef BIT_SERIALIZER_SKID_EN
  // A word arriving while the shifter is free (idle, or finishing with nothing
  // buffered) bypasses the buffer so its first bit still appears one cycle later.
  assign in_ready = !buf_full;
  assign load_in  = accept && (state_q == IDLE || (xfer_last && !buf_full));
  assign load_buf = xfer_last && buf_full;
  word_skid_buffer #(.WIDTH(WIDTH)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept && !load_in),
    .push_data (in_data),
    .pop       (load_buf),
    .full      (buf_full),
    .data      (buf_data)
  );
`else
  assign in_ready = state_q == IDLE;
  assign load_in  = accept;
  assign load_buf = 1'b0;
  assign buf_full = 1'b0;
  assign buf_data = '0;
`endif
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    idx_d   = idx_q;
    if (xfer) begin
      sreg_d  = LSB_FIRST ? {1'b0, sreg_q[WIDTH-1:1]} : {sreg_q[WIDTH-2:0], 1'b0};
      idx_d   = xfer_last ? '0 : idx_q + 1'b1;
      state_d = xfer_last ? IDLE : SHIFT;
    end
    if (load_buf) begin
      sreg_d  = buf_data;
      idx_d   = '0;
      state_d = SHIFT;
    end
    if (load_in) begin
      sreg_d  = in_data;
      idx_d   = '0;
      state_d = SHIFT;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      idx_q   <= idx_d;
    end
  end
  assign bit_out  = bit_valid && (LSB_FIRST ? sreg_q[0] : sreg_q[WIDTH-1]);
  assign bit_last = bit_valid && idx_q == LAST;
  assign busy     = bit_valid || buf_full;
endmodule
